// File: rtl/axil_pkg.sv
// Shared constants and helpers for the AXI-Lite UART master bridge.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package axil_pkg;

  localparam int         CLOCK       = 100_000_000;
  localparam int         BAUD_RATE   = 115_200;
  localparam logic [7:0] HEADER_UART = 8'hA5;

  // Response frame: status byte, address word, data word (status goes out first).
  localparam int RSP_FRAME_W = 72;

  // Bit positions inside the status byte.
  localparam int ST_IS_READ  = 7;
  localparam int ST_SEQ_LSB  = 4;
  localparam int ST_RESP_LSB = 0;

  // Builds one response frame; write responses carry no data, so the data word is zeroed.
  function automatic logic [RSP_FRAME_W-1:0] pack_rsp(
    input logic        is_read,
    input logic [2:0]  seq,
    input logic [1:0]  resp,
    input logic [31:0] addr,
    input logic [31:0] data
  );
    logic [7:0] status;
    status                    = '0;
    status[ST_IS_READ]        = is_read;
    status[ST_SEQ_LSB +: 3]   = seq;
    status[ST_RESP_LSB +: 2]  = resp;
    return {status, addr, (is_read ? data : 32'h0)};
  endfunction

endpackage

// File: rtl/axil_uart_rsp_pack_if.sv
// AXI-Stream link carrying packed response frames from the packer to the UART TX.
// Latency: none (wires only).
// Backpressure: tready from the TX; tdata/tvalid held until tvalid&&tready.
interface axis_if_uart;
  import axil_pkg::*;

  logic [RSP_FRAME_W-1:0] tdata;
  logic                   tvalid;
  logic                   tready;

  modport m_axis (output tdata, output tvalid, input tready);
  modport s_axis (input tdata, input tvalid, output tready);

endinterface

// File: rtl/axil_rsp_fifo.sv
// Frame buffer: register array with wrapping pointers and an occupancy counter.
// Latency: push to an empty FIFO shows out_vld one cycle later; no bypass.
// Backpressure: in_rdy and out_vld are registered from next-state count, independent of pop.
module axil_rsp_fifo #(
  parameter int WIDTH = 72,
  parameter int DEPTH = 4
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         in_dat,
  output logic                     in_rdy,
  input  logic                     pop,
  output logic [WIDTH-1:0]         out_dat,
  output logic                     out_vld,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_nxt;

  // Next occupancy: a simultaneous push and pop leave it unchanged.
  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + CW'(1);
    end else if (!push && pop) begin
      count_nxt = count - CW'(1);
    end
  end

  // Pointers, count and registered flags; reset drops everything buffered.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      in_rdy  <= 1'b0;
      out_vld <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count   <= count_nxt;
      in_rdy  <= (count_nxt != FULL);
      out_vld <= (count_nxt != '0);
    end
  end

  // Storage write; the head slot is never overwritten while it is still unread.
  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= in_dat;
  end

  assign out_dat = mem[rd_ptr];

  // Overflow and underflow cannot happen because both flags gate the handshakes.
  always @(posedge aclk) begin
    if (aresetn) begin
      assert (!(push && (count == FULL)));
      assert (!(pop && (count == '0)));
    end
  end

endmodule

// File: rtl/axil_uart_rsp_pack.sv
// Packs AXI-Lite response events into 72-bit frames and queues them for the UART TX.
// Latency: event accepted at edge N appears on m_axis at N+1; optional seq field via AXIL_RSP_SEQ_EN.
// Backpressure: rsp_ready drops only when the FIFO is full; never combinationally tied to tready.
module axil_uart_rsp_pack
  import axil_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   rsp_valid,
  output logic                   rsp_ready,
  input  logic                   rsp_is_read,
  input  logic [1:0]             rsp_resp,
  input  logic [31:0]            rsp_addr,
  input  logic [31:0]            rsp_data,
  output logic [$clog2(DEPTH):0] frames_pend,
  axis_if_uart.m_axis            m_axis
);

  logic                   push;
  logic                   pop;
  logic [2:0]             seq;
  logic [RSP_FRAME_W-1:0] frame;

  assign push = rsp_valid && rsp_ready;
  assign pop  = m_axis.tvalid && m_axis.tready;

`ifdef AXIL_RSP_SEQ_EN
  // Sequence tag advances on every accepted event so the host can spot dropped frames.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      seq <= 3'd0;
    end else if (push) begin
      seq <= seq + 3'd1;
    end
  end
`else
  assign seq = 3'b000;
`endif

  assign frame = pack_rsp(rsp_is_read, seq, rsp_resp, rsp_addr, rsp_data);

  axil_rsp_fifo #(
    .WIDTH (RSP_FRAME_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push    (push),
    .in_dat  (frame),
    .in_rdy  (rsp_ready),
    .pop     (pop),
    .out_dat (m_axis.tdata),
    .out_vld (m_axis.tvalid),
    .count   (frames_pend)
  );

endmodule
